// File: rtl/wb_sched_pkg.sv
// Shared definitions for the two-master Wishbone bus scheduler.
// Holds the FSM state encoding, master indices and the response payload.
package wb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        DRAIN  = 2'd3
    } sched_state_t;

    localparam logic M_DATA  = 1'b0;
    localparam logic M_FETCH = 1'b1;

    typedef struct packed {
        logic ack;
        logic err;
        logic rty;
    } wb_resp_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts unanswered strobe cycles and fires on the last allowed one.
// A response in the firing cycle wins, so fire is suppressed whenever any_resp is high.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic stb,
    input  logic any_resp,
    output logic fire
);

    localparam logic             ARMED = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    assign fire = ARMED && enable && stb && !any_resp && (cnt == LAST);

    // Counter restarts on any response, idle strobe, loss of grant or a firing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!ARMED || !enable || !stb || any_resp || fire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_sched_arbiter.sv
// Two-master Wishbone scheduler: data cache (m0) has priority, fetch (m1) is
// protected by a starvation guard; hung cycles are turned into errors by the watchdog.
module wb_sched_arbiter
    import wb_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_m0_cyc,
    input  logic i_m0_stb,
    input  logic i_m1_cyc,
    input  logic i_m1_stb,
    input  logic i_wb_ack,
    input  logic i_wb_err,
    input  logic i_wb_rty,
    output logic o_wb_cyc,
    output logic o_wb_stb,
    output logic o_sel,
    output logic o_m0_ack,
    output logic o_m0_err,
    output logic o_m0_rty,
    output logic o_m1_ack,
    output logic o_m1_err,
    output logic o_m1_rty,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    sched_state_t     state_q, state_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;
    logic             in_grant;
    logic             own_cyc;
    logic             own_stb;
    logic             any_resp;
    logic             wdt_fire;
    wb_resp_t         resp;

    assign in_grant   = (state_q == GRANT0) || (state_q == GRANT1);
    assign own_cyc    = (sel_q == M_FETCH) ? i_m1_cyc : i_m0_cyc;
    assign own_stb    = (sel_q == M_FETCH) ? i_m1_stb : i_m0_stb;
    assign any_resp   = i_wb_ack | i_wb_err | i_wb_rty;
    assign starve_hit = (starve_cnt == STARVE_LIM);

    // cyc follows the owner so the release cycle already shows cyc low.
    assign o_wb_cyc  = in_grant & own_cyc;
    assign o_wb_stb  = in_grant & own_cyc & own_stb;
    assign o_sel     = sel_q;
    assign o_timeout = wdt_fire;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdt (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .enable   (in_grant & i_rst),
        .stb      (o_wb_stb),
        .any_resp (any_resp),
        .fire     (wdt_fire)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            sel_q   <= M_DATA;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state selection and response routing to the current owner.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        resp    = '0;
        {o_m0_ack, o_m0_err, o_m0_rty} = 3'b000;
        {o_m1_ack, o_m1_err, o_m1_rty} = 3'b000;
        unique case (state_q)
            IDLE: begin
                if (i_m1_cyc && starve_hit) begin
                    state_d = GRANT1;
                    sel_d   = M_FETCH;
                end else if (i_m0_cyc) begin
                    state_d = GRANT0;
                    sel_d   = M_DATA;
                end else if (i_m1_cyc) begin
                    state_d = GRANT1;
                    sel_d   = M_FETCH;
                end
            end
            GRANT0, GRANT1: begin
                resp.ack = i_wb_ack;
                resp.err = i_wb_err | wdt_fire;
                resp.rty = i_wb_rty;
                if (wdt_fire) begin
                    state_d = DRAIN;
                end else if (!own_cyc) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (sel_q == M_FETCH) begin
            {o_m1_ack, o_m1_err, o_m1_rty} = resp;
        end else begin
            {o_m0_ack, o_m0_err, o_m0_rty} = resp;
        end
    end

    // Fetch wait counter: saturating, cleared when fetch idles or wins the bus.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            starve_cnt <= '0;
        end else if (!i_m1_cyc || (state_d == GRANT1 && state_q != GRANT1)) begin
            starve_cnt <= '0;
        end else if (state_q != GRANT1 && !starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_sched_arbiter.sv
// Directed bench for wb_sched_arbiter: inline bus/grant checks plus a response
// scoreboard whose monitor pops an expectation whenever any master response appears.
module tb_wb_sched_arbiter;

    typedef struct packed {
        logic m0_ack;
        logic m0_err;
        logic m0_rty;
        logic m1_ack;
        logic m1_err;
        logic m1_rty;
        logic tmo;
    } resp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    logic i_m0_cyc = 1'b0, i_m0_stb = 1'b0, i_m1_cyc = 1'b0, i_m1_stb = 1'b0;
    logic i_wb_ack = 1'b0, i_wb_err = 1'b0, i_wb_rty = 1'b0;
    logic o_wb_cyc, o_wb_stb, o_sel, o_timeout;
    logic o_m0_ack, o_m0_err, o_m0_rty, o_m1_ack, o_m1_err, o_m1_rty;

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t exp_q[$];

    wb_sched_arbiter #(
        .STARVE_MAX (8),
        .TIMEOUT    (4),
        .CNT_W      (8)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_m0_cyc  (i_m0_cyc),
        .i_m0_stb  (i_m0_stb),
        .i_m1_cyc  (i_m1_cyc),
        .i_m1_stb  (i_m1_stb),
        .i_wb_ack  (i_wb_ack),
        .i_wb_err  (i_wb_err),
        .i_wb_rty  (i_wb_rty),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .o_sel     (o_sel),
        .o_m0_ack  (o_m0_ack),
        .o_m0_err  (o_m0_err),
        .o_m0_rty  (o_m0_rty),
        .o_m1_ack  (o_m1_ack),
        .o_m1_err  (o_m1_err),
        .o_m1_rty  (o_m1_rty),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bus(input string name, input logic c, input logic s, input logic sel);
        check({name, "_cyc"}, 32'(o_wb_cyc), 32'(c));
        check({name, "_stb"}, 32'(o_wb_stb), 32'(s));
        check({name, "_sel"}, 32'(o_sel), 32'(sel));
    endtask

    task automatic drive(input logic m0c, input logic m0s, input logic m1c, input logic m1s,
                         input logic ack, input logic err, input logic rty);
        i_m0_cyc = m0c; i_m0_stb = m0s; i_m1_cyc = m1c; i_m1_stb = m1s;
        i_wb_ack = ack; i_wb_err = err; i_wb_rty = rty;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    // Scoreboard monitor: every non-zero response vector must match the next expectation.
    always @(negedge i_clk) begin
        resp_t act;
        resp_t exp;
        act = {o_m0_ack, o_m0_err, o_m0_rty, o_m1_ack, o_m1_err, o_m1_rty, o_timeout};
        if (act != '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: got %b expected none at %0t", act, $time);
            end else begin
                exp = exp_q.pop_front();
                check("resp", 32'(act), 32'(exp));
            end
        end
    end

    initial begin
        // Reset held for two edges.
        drive(0, 0, 0, 0, 0, 0, 0);
        i_rst = 1'b0;
        tick(); tick();
        mid();
        check("rst_outs", 32'({o_wb_cyc, o_wb_stb, o_sel, o_m0_ack, o_m0_err, o_m0_rty,
                               o_m1_ack, o_m1_err, o_m1_rty, o_timeout}), 32'd0);
        tick();

        // Single master 0 transfer.
        i_rst = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0); mid(); chk_bus("t1_req", 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 0); mid(); chk_bus("t1_grant", 1, 1, 0); tick();
        drive(1, 1, 0, 0, 1, 0, 0); exp_q.push_back(7'b1000000);
        mid(); check("t1_m1_ack", 32'(o_m1_ack), 32'd0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); mid(); chk_bus("t1_drop", 0, 0, 0); tick();
        tick();

        // Burst lock on master 1 with m0 arriving mid-burst.
        drive(0, 0, 1, 1, 0, 0, 0); mid(); chk_bus("t2_req", 0, 0, 0); tick();
        for (int b = 0; b < 8; b++) begin
            logic m0c;
            m0c = (b >= 3);
            if (b == 5) begin
                drive(m0c, m0c, 1, 1, 1, 1, 0); exp_q.push_back(7'b0001100);
            end else if (b == 6) begin
                drive(m0c, m0c, 1, 1, 0, 0, 1); exp_q.push_back(7'b0000010);
            end else begin
                drive(m0c, m0c, 1, 1, 1, 0, 0); exp_q.push_back(7'b0001000);
            end
            mid(); chk_bus($sformatf("t2_beat%0d", b), 1, 1, 1); tick();
        end
        drive(1, 1, 0, 0, 0, 0, 0); mid(); chk_bus("t2_drop", 0, 0, 1); tick();
        drive(1, 1, 0, 0, 0, 0, 0); mid(); chk_bus("t2_gap", 0, 0, 1); tick();
        drive(1, 1, 0, 0, 1, 0, 0); exp_q.push_back(7'b1000000);
        mid(); chk_bus("t2_g0", 1, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        tick();

        // Starvation: m1 waits through three m0 cycles, then wins at starve_cnt==8.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 1, 0, 0, 0); mid(); chk_bus($sformatf("t3_idle%0d", k), 0, 0, 0); tick();
            drive(1, 1, 1, 1, 1, 0, 0); exp_q.push_back(7'b1000000);
            mid(); chk_bus($sformatf("t3_g0_%0d", k), 1, 1, 0); tick();
            drive(0, 0, 1, 1, 0, 0, 0); mid(); chk_bus($sformatf("t3_drop%0d", k), 0, 0, 0); tick();
        end
        drive(1, 1, 1, 1, 0, 0, 0); mid();
        chk_bus("t3_starved_idle", 0, 0, 0);
        check("t3_starve_full", 32'(dut.starve_cnt), 32'd8); tick();
        drive(1, 1, 1, 1, 1, 0, 0); exp_q.push_back(7'b0001000);
        mid(); chk_bus("t3_g1", 1, 1, 1);
        check("t3_starve_clear", 32'(dut.starve_cnt), 32'd0); tick();
        drive(1, 1, 0, 0, 0, 0, 0); mid(); chk_bus("t3_g1_drop", 0, 0, 1); tick();
        drive(1, 1, 0, 0, 0, 0, 0); mid(); chk_bus("t3_idle_after", 0, 0, 1); tick();
        drive(1, 1, 0, 0, 1, 0, 0); exp_q.push_back(7'b1000000);
        mid(); chk_bus("t3_g0_after", 1, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        tick();

        // Watchdog timeout on the 4th unanswered strobe, late ack dropped in DRAIN.
        drive(1, 1, 0, 0, 0, 0, 0); mid(); tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0); mid();
            chk_bus($sformatf("t4_wait%0d", i), 1, 1, 0);
            check($sformatf("t4_tmo%0d", i), 32'(o_timeout), 32'd0); tick();
        end
        drive(1, 1, 0, 0, 0, 0, 0); exp_q.push_back(7'b0100001);
        mid(); chk_bus("t4_fire", 1, 1, 0); tick();
        drive(1, 1, 0, 0, 1, 0, 0); mid(); chk_bus("t4_drain", 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); mid(); chk_bus("t4_release", 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 0); mid(); chk_bus("t4_idle", 0, 0, 0); tick();
        drive(1, 1, 0, 0, 1, 0, 0); exp_q.push_back(7'b1000000);
        mid(); chk_bus("t4_regrant", 1, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        tick();

        // Watchdog race: ack on the firing cycle wins and grant is kept.
        drive(1, 1, 0, 0, 0, 0, 0); mid(); tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0); mid(); tick();
        end
        drive(1, 1, 0, 0, 1, 0, 0); exp_q.push_back(7'b1000000);
        mid(); check("t5_tmo", 32'(o_timeout), 32'd0); tick();
        drive(1, 1, 0, 0, 0, 0, 0); mid(); chk_bus("t5_retained", 1, 1, 0); tick();
        drive(1, 1, 0, 0, 1, 0, 0); exp_q.push_back(7'b1000000); mid(); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        tick();

        // Reset during a master 1 burst.
        drive(0, 0, 1, 1, 0, 0, 0); mid(); tick();
        drive(0, 0, 1, 1, 0, 0, 0); mid(); chk_bus("t6_g1", 1, 1, 1); tick();
        i_rst = 1'b0;
        drive(0, 0, 1, 1, 0, 0, 0); mid(); tick();
        drive(0, 0, 1, 1, 0, 0, 0); mid(); chk_bus("t6_after_rst", 0, 0, 0); tick();
        i_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_sched_arbiter.md
Name: wb_sched_arbiter

Overview:
- Two-master Wishbone bus scheduler for the upper core. Master 0 is the data cache; master 1 is the instruction cache.
- Owns bus ownership sequencing: registered grant, grant held for the whole burst, starvation guard for fetch, and a bus watchdog that converts hung cycles into errors.
- Address, data, sel and burst muxing stay outside this block and use o_sel. This block produces cyc/stb and routes responses.

Parameters:
- STARVE_MAX, 8: consecutive cycles master 1 may wait before it wins over master 0 (1..255).
- TIMEOUT, 64: cycles with o_wb_stb high and no response before an error is injected. 0 disables the watchdog.
- CNT_W, 8: width of the starve and watchdog counters. Must hold max(STARVE_MAX, TIMEOUT).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_m0_cyc, i_m0_stb  in  1 each  master 0 (data) request.
- i_m1_cyc, i_m1_stb  in  1 each  master 1 (fetch) request.
- i_wb_ack, i_wb_err, i_wb_rty  in  1 each  bus responses.
- o_wb_cyc, o_wb_stb  out  1 each  bus cycle and strobe.
- o_sel  out  1  current owner: 0 = master 0, 1 = master 1. Drives the external muxes.
- o_m0_ack, o_m0_err, o_m0_rty  out  1 each  responses routed to master 0.
- o_m1_ack, o_m1_err, o_m1_rty  out  1 each  responses routed to master 1.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- States: IDLE, GRANT0, GRANT1, DRAIN. Encoding lives in the package. State and o_sel are registered.
- Reset (i_rst=0 at a clock edge):
  - state=IDLE, o_sel=0, starve_cnt=0, wdt_cnt=0.
  - All outputs 0. o_timeout=0.
- IDLE: o_wb_cyc=0, o_wb_stb=0, all master responses 0. Next state:
  - m1_cyc and starve_cnt==STARVE_MAX -> GRANT1, o_sel<=1.
  - else m0_cyc -> GRANT0, o_sel<=0.
  - else m1_cyc -> GRANT1, o_sel<=1.
  - else stay IDLE.
  - Latency: request seen in cycle N gives o_wb_cyc=1 in cycle N+1.
- GRANTx:
  - o_wb_cyc=1 and o_wb_stb=i_mx_stb, both combinational.
  - Bus ack/err/rty are forwarded combinationally to master x only. The other master's responses are held 0.
  - Grant is held while i_mx_cyc=1, regardless of the other master (burst lock).
  - When i_mx_cyc=0: go to IDLE next cycle. o_wb_cyc=0 in that cycle. This gives a mandatory one-cycle dead gap between owners.
- Starve counter:
  - Increments when i_m1_cyc=1 and state!=GRANT1. Saturates at STARVE_MAX.
  - Clears on entry to GRANT1, and whenever i_m1_cyc=0.
- Watchdog (TIMEOUT>0):
  - wdt_cnt increments each cycle with o_wb_stb=1 and no ack/err/rty.
  - Clears on any response, when stb=0, or outside GRANT states.
  - When wdt_cnt==TIMEOUT-1 and still no response, all in the same cycle: assert o_mx_err=1 for that cycle, pulse o_timeout=1, clear wdt_cnt.
  - Next state is DRAIN.
- DRAIN:
  - o_wb_cyc=0, o_wb_stb=0. Bus responses are dropped, not forwarded.
  - Stay until the owning master drops cyc, then go to IDLE.
  - o_sel is held through DRAIN.
- Simultaneous events:
  - A real response arriving in the same cycle the watchdog would fire wins. It is forwarded and no timeout occurs.
  - err and ack together are forwarded unchanged; the master resolves them.
- Reset asserted mid-burst: the bus drops cyc on the next edge with no error to either master.

Decomposition:
- Shared package wb_sched_pkg:
  - state encoding: IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2, DRAIN=2'd3.
  - master index constants: M_DATA=0, M_FETCH=1.
- One natural sub-module: wb_watchdog, holding the counter, compare and the o_timeout pulse. It takes stb, any_resp and enable, and outputs fire.
- Starve logic and the FSM stay in the top.

Test Plan:
- Reset and single master 0 request:
  - Hold i_rst=0 for 2 cycles -> all outputs 0.
  - Raise m0_cyc/stb at cycle 5 -> o_wb_cyc=1 and o_sel=0 at cycle 6.
  - Ack at cycle 8 -> o_m0_ack=1 at cycle 8 and o_m1_ack=0.
- Burst lock:
  - Master 1 holds cyc for an 8-beat burst while m0_cyc rises mid-burst -> o_sel stays 1 until m1_cyc drops.
  - One idle cycle follows, then GRANT0.
- Priority and starvation:
  - m0 issues back-to-back cycles while m1_cyc is held high continuously, STARVE_MAX=8.
  - Once starve_cnt reaches 8, the next IDLE grants master 1 even with m0_cyc=1.
  - starve_cnt reads 0 after the grant.
- Watchdog timeout:
  - TIMEOUT=4, m0 strobes and the bus never responds.
  - 4th stb cycle -> o_m0_err=1 and o_timeout=1. Next cycle -> o_wb_cyc=0 (DRAIN).
  - m0 drops cyc -> IDLE.
  - A late i_wb_ack during DRAIN is not forwarded.
- Watchdog race:
  - TIMEOUT=4, ack arrives on the 4th stb cycle -> o_m0_ack=1, o_timeout=0, grant retained.
- Reset mid-burst:
  - i_rst=0 during GRANT1 -> next edge state=IDLE, o_wb_cyc=0, o_sel=0, no err pulse to either master.
